hash_round_engine: RTL
======================

// Module: hash_round_engine
// PURPOSE
//  Iterative, parametrised hash-round engine. Absorbs one NW-word message block plus IV,
//  applies N_ROUNDS rounds (one per clock), and presents the digest via valid/ready.
//  Generalises the single combinational round: runtime sequencing, round counter,
//  per-round constants and output backpressure. Sits between block loader and digest sink.
// PARAMETERS
//  W         8   word width in bits (>=4)
//  NW        4   words per state (>=2)
//  N_ROUNDS  12  rounds per block (1..255)
//  RHO_STEP  1   rho rotate increment per word index
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  in_valid   in   1       msg_in/iv_in valid
//  in_ready   out  1       engine can accept a block
//  msg_in     in   NWxW    message words [0:NW-1]
//  iv_in      in   NWxW    IV words [0:NW-1]
//  abort      in   1       synchronous abort, returns to IDLE
//  out_valid  out  1       hash_out valid
//  out_ready  in   1       sink accepts hash_out
//  hash_out   out  NWxW    digest words [0:NW-1]
//  busy       out  1       high in CALC_SA / CALC_ROUND
//  round_idx  out  8       current round index
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, H/IV regs=0, round_idx=0, out_valid=0,
//   in_ready=1, busy=0, hash_out=0. Reset mid-block discards it; no partial output.
//  FSM: IDLE -(in_valid)-> CALC_SA -> CALC_ROUND x(N_ROUNDS-1) -> DONE -(out_ready)-> IDLE.
//   N_ROUNDS=1: CALC_SA -> DONE directly.
//  Accept: in_valid&in_ready in IDLE latches H<=msg_in, IVr<=iv_in, round_idx<=0.
//  in_ready=1 only in IDLE; in_valid ignored elsewhere.
//  Round function (mod 2^W), r=round_idx:
//   mix:   CALC_SA    M[i]=H[i]+IVr[i] (carry dropped);
//          CALC_ROUND M[i]=H[i]^IVr[i]^r[W-1:0] (r zero-extended/truncated to W)
//   theta: T[i]=M[i]^M[(i+1) mod NW]
//   rho:   H'[i]=rotl(T[i], (i*RHO_STEP) mod W)
//  Each CALC_* cycle: H<=H', round_idx<=r+1. Round N_ROUNDS-1 enters DONE.
//  Latency: accept at cycle 0 -> out_valid=1 at cycle N_ROUNDS.
//  DONE: out_valid=1, hash_out=H held stable until out_ready; transfer -> IDLE,
//   out_valid=0 next cycle, round_idx=0. Input cannot be accepted on the transfer cycle.
//  abort=1: any state -> IDLE next cycle, out_valid=0, H unchanged; abort beats out_ready
//   and in_valid in the same cycle.
//  hash_out driven from H register only (no combinational path from inputs).
// STRUCTURE
//  hash_pkg: state_t enum {IDLE, CALC_SA, CALC_ROUND, DONE}; default W/NW/N_ROUNDS consts.
//  Sub-module hash_round_comb (combinational mix/theta/rho, params W,NW,RHO_STEP;
//   inputs H, IV, mode, r; output H'). Engine holds FSM, counter, registers.
// TESTING
//  1 N_ROUNDS=1,W=8,NW=4: msg={01,00,00,00}, IV=0 -> hash_out={01,00,00,08}, out_valid at cycle 1.
//  2 Defaults, msg=0, IV=0 -> out_valid exactly at cycle 12; result matches golden model.
//  3 SA carry: N_ROUNDS=1, msg={FF,00,00,00}, IV={01,00,00,00} -> mix word0=00, hash_out=0.
//  4 Hold out_ready=0 for 5 cycles in DONE -> out_valid, hash_out stable; in_ready=0 throughout.
//  5 abort at round 5 -> IDLE next cycle, in_ready=1, no out_valid; rst_n low at round 7 -> all
//    outputs at reset values immediately, asynchronously.
//  6 Back-to-back: 10 random blocks, out_ready random -> every digest matches model, none lost.

Source files
------------

// File: rtl/hash_round_engine_pkg.sv
// Shared types and default sizing for the iterative hash-round engine.
package hash_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC_SA,
        CALC_ROUND,
        DONE
    } state_t;

    typedef enum logic {
        MIX_ADD,
        MIX_XOR
    } mix_mode_t;

    localparam int unsigned DEF_W        = 8;
    localparam int unsigned DEF_NW       = 4;
    localparam int unsigned DEF_N_ROUNDS = 12;
    localparam int unsigned DEF_RHO_STEP = 1;

endpackage

// File: rtl/hash_round_engine_if.sv
// Block-in / digest-out handshake bundle for hash_round_engine.
interface hash_round_engine_if #(
    parameter int unsigned W  = 8,
    parameter int unsigned NW = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [NW-1:0][W-1:0]   msg_in;
    logic [NW-1:0][W-1:0]   iv_in;
    logic                   abort;
    logic                   out_valid;
    logic                   out_ready;
    logic [NW-1:0][W-1:0]   hash_out;
    logic                   busy;
    logic [7:0]             round_idx;

    modport master (
        output in_valid, msg_in, iv_in, abort, out_ready,
        input  in_ready, out_valid, hash_out, busy, round_idx
    );

    modport slave (
        input  in_valid, msg_in, iv_in, abort, out_ready,
        output in_ready, out_valid, hash_out, busy, round_idx
    );
endinterface

// File: rtl/hash_round_comb.sv
// One combinational round: mix (add or xor with round index), theta, rho.
module hash_round_comb
    import hash_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned NW       = DEF_NW,
    parameter int unsigned RHO_STEP = DEF_RHO_STEP
) (
    input  logic [NW-1:0][W-1:0] h,
    input  logic [NW-1:0][W-1:0] iv,
    input  mix_mode_t            mode,
    input  logic [7:0]           r,
    output logic [NW-1:0][W-1:0] h_next
);

    logic [NW-1:0][W-1:0] mix;
    logic [NW-1:0][W-1:0] theta;
    logic [W-1:0]         r_w;
    logic [2*W-1:0]       dbl;

    always_comb begin
        mix    = '0;
        theta  = '0;
        h_next = '0;
        dbl    = '0;
        r_w    = W'(r);
        for (int unsigned i = 0; i < NW; i++) begin
            mix[i] = (mode == MIX_ADD) ? (h[i] + iv[i]) : (h[i] ^ iv[i] ^ r_w);
        end
        for (int unsigned i = 0; i < NW; i++) begin
            theta[i] = mix[i] ^ mix[(i + 1) % NW];
        end
        // Rotate-left via the upper half of a doubled word shifted left.
        for (int unsigned i = 0; i < NW; i++) begin
            dbl       = {theta[i], theta[i]} << ((i * RHO_STEP) % W);
            h_next[i] = dbl[2*W-1:W];
        end
    end

endmodule

// File: rtl/hash_round_engine.sv
// Iterative hash-round engine: absorbs a block + IV, runs N_ROUNDS rounds, holds digest until taken.
module hash_round_engine
    import hash_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned NW       = DEF_NW,
    parameter int unsigned N_ROUNDS = DEF_N_ROUNDS,
    parameter int unsigned RHO_STEP = DEF_RHO_STEP
) (
    input logic                 clk,
    input logic                 rst_n,
    hash_round_engine_if.slave  bus
);

    localparam logic [7:0] LAST_ROUND = 8'(N_ROUNDS - 1);

    state_t               state_q, state_d;
    logic [NW-1:0][W-1:0] h_q, h_d;
    logic [NW-1:0][W-1:0] iv_q, iv_d;
    logic [7:0]           round_q, round_d;
    logic [NW-1:0][W-1:0] h_round;
    mix_mode_t            mode;

    assign mode = (state_q == CALC_SA) ? MIX_ADD : MIX_XOR;

    hash_round_comb #(
        .W        (W),
        .NW       (NW),
        .RHO_STEP (RHO_STEP)
    ) u_round (
        .h      (h_q),
        .iv     (iv_q),
        .mode   (mode),
        .r      (round_q),
        .h_next (h_round)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            h_q     <= '0;
            iv_q    <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            iv_q    <= iv_d;
            round_q <= round_d;
        end
    end

    // Abort has priority over every other transition, including accept and transfer.
    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:                state_d = bus.in_valid ? CALC_SA : IDLE;
                CALC_SA, CALC_ROUND: state_d = (round_q == LAST_ROUND) ? DONE : CALC_ROUND;
                DONE:                state_d = bus.out_ready ? IDLE : DONE;
                default:             state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        h_d     = h_q;
        iv_d    = iv_q;
        round_d = round_q;
        if (bus.abort) begin
            round_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        h_d     = bus.msg_in;
                        iv_d    = bus.iv_in;
                        round_d = '0;
                    end
                end
                CALC_SA, CALC_ROUND: begin
                    h_d     = h_round;
                    round_d = round_q + 8'd1;
                end
                DONE: begin
                    if (bus.out_ready) round_d = '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.busy      = (state_q == CALC_SA) || (state_q == CALC_ROUND);
        bus.out_valid = (state_q == DONE);
        bus.hash_out  = h_q;
        bus.round_idx = round_q;
    end

endmodule
